// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised serial transmitter fed by a small word FIFO.
// Words enter through a valid/ready write port and go out LSB-first as
// start / data / optional parity / stop frames, back-to-back while queued.
//
// Handshake: a word is transferred on a rising edge where wr_valid && wr_ready.
// wr_ready is a combinational copy of "FIFO not full"; wr_data is ignored
// whenever wr_ready is low.

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_BITS-1:0]              wr_data,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    output logic                              tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic [2:0]                        state_dbg
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic             PAR_INV   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CW-1:0]        count;

    state_t               state;
    logic [CNT_W-1:0]     cyc_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_acc;

    logic full;
    logic empty;
    logic wr_en;
    logic bit_end;
    logic frame_end;
    logic pop;

    assign full       = (count == CW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign wr_en      = wr_valid && !full;
    assign bit_end    = (cyc_cnt == CNT_LAST);
    assign frame_end  = (state == S_STOP) && bit_end && (bit_cnt == STOP_LAST);
    // A queued word moves into the shifter when idle or on the very last
    // stop-bit cycle, which is what makes consecutive frames gapless.
    assign pop        = !empty && ((state == S_IDLE) || frame_end);

    assign wr_ready   = !full;
    assign busy       = (state != S_IDLE) || !empty;
    assign fifo_count = count;
    assign state_dbg  = state;

    // FIFO storage: written on accepted words only, contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; a write and pop on one edge cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer; tx is registered and set to the value of the slot being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par_acc <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        par_acc <= 1'b0;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        tx      <= shift[0];
                        state   <= S_DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        par_acc <= par_acc ^ shift[0];
                        shift   <= shift >> 1;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                tx    <= par_acc ^ shift[0] ^ PAR_INV;
                                state <= S_PAR;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                S_PAR: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= S_STOP;
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                shift   <= mem[rd_ptr];
                                par_acc <= 1'b0;
                                tx      <= 1'b0;
                                state   <= S_START;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scoreboard bench for uart_tx_fifo.
// Three instances cover the default frame, odd parity, and a 7-bit / no
// parity / two-stop configuration. Writers push hand-built expected frames;
// per-instance line monitors decode tx and compare against the queues.

module tb_uart_tx_fifo;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [7:0] wr_data0, wr_data1;
  logic [6:0] wr_data2;
  logic       wr_valid0, wr_valid1, wr_valid2;
  logic       wr_ready0, wr_ready1, wr_ready2;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic [2:0] count0, count1, count2;
  logic [2:0] st0, st1, st2;

  uart_tx_fifo u0 (
    .clk(clk), .rst(rst), .wr_data(wr_data0), .wr_valid(wr_valid0),
    .wr_ready(wr_ready0), .tx(tx0), .busy(busy0), .fifo_count(count0),
    .state_dbg(st0)
  );

  uart_tx_fifo #(.PARITY(2)) u1 (
    .clk(clk), .rst(rst), .wr_data(wr_data1), .wr_valid(wr_valid1),
    .wr_ready(wr_ready1), .tx(tx1), .busy(busy1), .fifo_count(count1),
    .state_dbg(st1)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .wr_data(wr_data2), .wr_valid(wr_valid2),
    .wr_ready(wr_ready2), .tx(tx2), .busy(busy2), .fifo_count(count2),
    .state_dbg(st2)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q2[$];
  int          starts1[$];
  int          checks = 0;
  int          fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic tx_of(input int idx);
    case (idx)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic ready_of(input int idx);
    case (idx)
      0:       return wr_ready0;
      1:       return wr_ready1;
      default: return wr_ready2;
    endcase
  endfunction

  function automatic logic busy_of(input int idx);
    case (idx)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  // Line monitor: on a start bit, sample every cycle of every slot; the slot
  // value is its first sample and any later disagreement marks the frame unstable.
  task automatic mon(input int idx, input int cpb, input int nslot);
    logic [15:0] capt;
    logic [15:0] e;
    logic        stable;
    logic        aborted;
    int          t0;
    forever begin
      @(negedge clk);
      if (!rst && tx_of(idx) === 1'b0) begin
        capt    = '0;
        stable  = 1'b1;
        aborted = 1'b0;
        t0      = cyc;
        for (int s = 0; s < nslot; s++) begin
          for (int k = 0; k < cpb; k++) begin
            if (!(s == 0 && k == 0)) @(negedge clk);
            if (rst) aborted = 1'b1;
            if (k == 0) capt[s] = tx_of(idx);
            else if (tx_of(idx) !== capt[s]) stable = 1'b0;
          end
        end
        if (!aborted) begin
          if (idx == 1) starts1.push_back(t0);
          e = 16'hxxxx;
          case (idx)
            0: if (exp_q0.size() > 0) e = exp_q0.pop_front();
            1: if (exp_q1.size() > 0) e = exp_q1.pop_front();
            default: if (exp_q2.size() > 0) e = exp_q2.pop_front();
          endcase
          checks++;
          if (capt !== e || !stable) begin
            fails++;
            $display("FAIL frame_u%0d: got frame 0x%0h stable=%0b, expected 0x%0h stable=1 (start cycle %0d)",
                     idx, capt, stable, e, t0);
          end
        end
      end
    end
  endtask

  initial mon(0, 16, 11);
  initial mon(1, 16, 11);
  initial mon(2, 4, 10);

  // ---------------- driver tasks ----------------
  // Caller sits just after a rising edge; returns just after the accept edge.
  task automatic wr(input int idx, input logic [7:0] d, input logic par);
    int t = 0;
    while (!ready_of(idx) && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 1000) chk("wr_ready_timeout", 32'(t), 32'd0);
    case (idx)
      0: begin
        wr_valid0 = 1'b1; wr_data0 = d;
        exp_q0.push_back({5'b0, 1'b1, par, d, 1'b0});
      end
      1: begin
        wr_valid1 = 1'b1; wr_data1 = d;
        exp_q1.push_back({5'b0, 1'b1, par, d, 1'b0});
      end
      default: begin
        wr_valid2 = 1'b1; wr_data2 = d[6:0];
        exp_q2.push_back({6'b0, 2'b11, d[6:0], 1'b0});
      end
    endcase
    @(posedge clk); #1;
    wr_valid0 = 1'b0; wr_valid1 = 1'b0; wr_valid2 = 1'b0;
  endtask

  task automatic wait_idle(input int idx, input int budget, output int at_cyc);
    int t = 0;
    while (busy_of(idx) && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= budget) chk("busy_timeout", 32'(t), 32'd0);
    at_cyc = cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int c1;
    int done;
    int acc;
    int lows;
    logic [7:0] v;

    rst = 1'b1;
    wr_valid0 = 1'b0; wr_valid1 = 1'b0; wr_valid2 = 1'b0;
    wr_data0 = '0; wr_data1 = '0; wr_data2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx", 32'(tx0), 32'd1);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_count", 32'(count0), 32'd0);
    chk("reset_wr_ready", 32'(wr_ready0), 32'd1);
    chk("reset_tx_u2", 32'(tx2), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single 0xA5 frame: latency, count, and busy length of 176 cycles.
    wr(0, 8'hA5, 1'b0);
    c = cyc;
    chk("t1_count_after_write", 32'(count0), 32'd1);
    chk("t1_tx_still_idle", 32'(tx0), 32'd1);
    chk("t1_busy_on_queue", 32'(busy0), 32'd1);
    @(posedge clk); #1;
    chk("t1_tx_start", 32'(tx0), 32'd0);
    chk("t1_count_after_load", 32'(count0), 32'd0);
    wait_idle(0, 400, done);
    chk("t1_busy_drop_cycle", 32'(done - (c + 1)), 32'd176);
    repeat (3) @(posedge clk); #1;

    // Odd parity, two back-to-back frames.
    wr(1, 8'h00, 1'b1);
    c = cyc;
    wr(1, 8'hFF, 1'b1);
    wait_idle(1, 800, done);
    chk("t2_busy_drop_cycle", 32'(done - (c + 1)), 32'd352);
    repeat (3) @(posedge clk); #1;
    chk("t2_frames_seen", 32'(starts1.size()), 32'd2);
    if (starts1.size() == 2)
      chk("t2_back_to_back", 32'(starts1[1] - starts1[0]), 32'd176);

    // Streaming writes until the FIFO fills.
    acc = 0;
    c1 = 0;
    for (int i = 1; i <= 8; i++) begin
      v = 8'(i);
      wr_valid0 = 1'b1;
      wr_data0  = v;
      if (wr_ready0) begin
        acc++;
        // Even parity of 0x01..0x05 worked out by hand: 1,1,0,1,0.
        case (i)
          1: exp_q0.push_back({5'b0, 1'b1, 1'b1, v, 1'b0});
          2: exp_q0.push_back({5'b0, 1'b1, 1'b1, v, 1'b0});
          3: exp_q0.push_back({5'b0, 1'b1, 1'b0, v, 1'b0});
          4: exp_q0.push_back({5'b0, 1'b1, 1'b1, v, 1'b0});
          default: exp_q0.push_back({5'b0, 1'b1, 1'b0, v, 1'b0});
        endcase
      end
      @(posedge clk); #1;
      if (i == 1) c1 = cyc;
    end
    wr_valid0 = 1'b0;
    chk("t3_accepted", 32'(acc), 32'd5);
    chk("t3_count_full", 32'(count0), 32'd4);
    chk("t3_wr_ready_low", 32'(wr_ready0), 32'd0);
    begin
      int t = 0;
      while (!wr_ready0 && t < 400) begin
        @(posedge clk); #1;
        t++;
      end
    end
    chk("t3_wr_ready_rise_cycle", 32'(cyc - c1), 32'd177);
    wait_idle(0, 1200, done);
    repeat (3) @(posedge clk); #1;
    chk("t3_queue_drained", 32'(exp_q0.size()), 32'd0);

    // 7 data bits, no parity, two stop bits, 4 clocks per bit.
    wr(2, 8'h55, 1'b0);
    c = cyc;
    wait_idle(2, 200, done);
    chk("t4_frame_cycles", 32'(done - (c + 1)), 32'd40);
    repeat (3) @(posedge clk); #1;

    // Reset 60 cycles into a frame with two words queued.
    wr(0, 8'h11, 1'b0);
    c = cyc;
    wr(0, 8'h22, 1'b0);
    wr(0, 8'h33, 1'b0);
    chk("t5_count_before", 32'(count0), 32'd2);
    while (cyc < c + 1 + 60) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q0.delete();
    chk("t5_tx_high", 32'(tx0), 32'd1);
    chk("t5_busy_low", 32'(busy0), 32'd0);
    chk("t5_count_zero", 32'(count0), 32'd0);
    chk("t5_wr_ready", 32'(wr_ready0), 32'd1);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (tx0 !== 1'b1) lows++;
    end
    chk("t5_no_start_after_reset", 32'(lows), 32'd0);
    chk("t5_still_idle", 32'(busy0), 32'd0);

    // Write on the same edge that pops at the end of a stop bit.
    wr(0, 8'h3C, 1'b0);
    c = cyc;
    wr(0, 8'h81, 1'b0);
    wr(0, 8'h07, 1'b1);
    while (cyc < c + 176) begin
      @(posedge clk); #1;
    end
    chk("t6_count_pre_edge", 32'(count0), 32'd2);
    chk("t6_tx_in_stop", 32'(tx0), 32'd1);
    wr(0, 8'h10, 1'b1);
    chk("t6_count_same", 32'(count0), 32'd2);
    chk("t6_next_start", 32'(tx0), 32'd0);
    wait_idle(0, 1000, done);
    repeat (3) @(posedge clk); #1;

    chk("final_q0_empty", 32'(exp_q0.size()), 32'd0);
    chk("final_q1_empty", 32'(exp_q1.size()), 32'd0);
    chk("final_q2_empty", 32'(exp_q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
